// File: rtl/rst_sequencer.sv
// Board-level reset sequencer: synchronizes clock lock and reset button, debounces
// the button, and holds the SoC in reset until the clock is stable.
module rst_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       locked_i,
    input  logic       btn_ni,
    output logic       soc_reset_no,
    output logic [1:0] reset_cause_o,
    output logic [7:0] reset_count_o
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    // The RUN cycle that first sees the button low is low cycle 1, so DEBOUNCE
    // only has to count the remaining DEBOUNCE_CYCLES-1 of them.
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 2);

    localparam logic [1:0] CAUSE_POR  = 2'b01;
    localparam logic [1:0] CAUSE_LOCK = 2'b10;
    localparam logic [1:0] CAUSE_BTN  = 2'b11;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLD      = 3'd1,
        RUN       = 3'd2,
        DEBOUNCE  = 3'd3,
        WAIT_REL  = 3'd4
    } state_t;

    state_t              state_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic [DEB_W-1:0]    deb_cnt_r;
    logic [1:0]          cause_r;
    logic [7:0]          count_r;
    logic                soc_reset_r;
    logic [SYNC_STAGES-1:0] lock_sync_r;
    logic [SYNC_STAGES-1:0] btn_sync_r;
    logic                lock_s;
    logic                btn_s;
    logic                lock_lost_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Metastability synchronizers; reset values represent "not locked, button released".
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            lock_sync_r <= '0;
            btn_sync_r  <= '1;
        end else begin
            lock_sync_r <= {lock_sync_r[SYNC_STAGES-2:0], locked_i};
            btn_sync_r  <= {btn_sync_r[SYNC_STAGES-2:0], btn_ni};
        end
    end

    assign lock_s      = lock_sync_r[SYNC_STAGES-1];
    assign btn_s       = btn_sync_r[SYNC_STAGES-1];
    assign lock_lost_s = !lock_s && (state_r inside {HOLD, RUN, DEBOUNCE, WAIT_REL});

    // Sequencer FSM with its counters, cause/count bookkeeping and registered reset output.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_r     <= WAIT_LOCK;
            hold_cnt_r  <= '0;
            deb_cnt_r   <= '0;
            cause_r     <= CAUSE_POR;
            count_r     <= 8'd0;
            soc_reset_r <= 1'b0;
        end else begin
            soc_reset_r <= (state_r == RUN) || (state_r == DEBOUNCE);
            if (lock_lost_s) begin
                // Lock loss outranks any button event in the same cycle.
                state_r    <= WAIT_LOCK;
                cause_r    <= CAUSE_LOCK;
                count_r    <= sat_inc(count_r);
                hold_cnt_r <= '0;
                deb_cnt_r  <= '0;
            end else begin
                case (state_r)
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state_r    <= HOLD;
                            hold_cnt_r <= '0;
                        end else begin
                            state_r <= WAIT_LOCK;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            state_r <= RUN;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                        end
                    end
                    RUN: begin
                        if (!btn_s) begin
                            state_r   <= DEBOUNCE;
                            deb_cnt_r <= '0;
                        end else begin
                            state_r <= RUN;
                        end
                    end
                    DEBOUNCE: begin
                        if (btn_s) begin
                            state_r <= RUN;
                        end else if (deb_cnt_r == DEB_LAST) begin
                            state_r <= WAIT_REL;
                            cause_r <= CAUSE_BTN;
                            count_r <= sat_inc(count_r);
                        end else begin
                            deb_cnt_r <= deb_cnt_r + DEB_W'(1);
                        end
                    end
                    WAIT_REL: begin
                        if (btn_s) begin
                            state_r    <= HOLD;
                            hold_cnt_r <= '0;
                        end else begin
                            state_r <= WAIT_REL;
                        end
                    end
                    default: begin
                        state_r    <= WAIT_LOCK;
                        hold_cnt_r <= '0;
                        deb_cnt_r  <= '0;
                    end
                endcase
            end
        end
    end

    assign soc_reset_no  = soc_reset_r;
    assign reset_cause_o = cause_r;
    assign reset_count_o = count_r;

endmodule
